// File: rtl/axi_lite_pt_monitor.sv
// Passive AXI4-Lite monitor: transaction/error counters, outstanding tracking,
// worst-case read latency via a timestamp FIFO, and sticky protocol violations.
module axi_lite_pt_monitor #(
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int CNT_W           = 32,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             clr,
  input  logic             awvalid,
  input  logic             awready,
  input  logic             wvalid,
  input  logic             wready,
  input  logic             arvalid,
  input  logic             arready,
  input  logic             bvalid,
  input  logic             bready,
  input  logic             rvalid,
  input  logic             rready,
  input  logic [1:0]       bresp,
  input  logic [1:0]       rresp,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] err_count,
  output logic [OUT_W-1:0] wr_outstanding,
  output logic [OUT_W-1:0] rd_outstanding,
  output logic [CNT_W-1:0] rd_lat_max,
  output logic [7:0]       viol,
  output logic             irq
);

  localparam int             PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] ts_q, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] lat_max_q, lat_max_d, lat;
  logic [OUT_W-1:0] wr_out_q, wr_out_d, rd_out_q, rd_out_d, fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] mem_q [MAX_OUTSTANDING];
  logic [7:0]       viol_q, viol_d, viol_new;
  logic [4:0]       stall_q, stall_d;
  logic             irq_q;
  logic             aw_hs, ar_hs, b_hs, r_hs, push, pop;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // A response at zero holds the count at zero even if a request arrives alongside.
  function automatic logic [OUT_W-1:0] next_out(input logic [OUT_W-1:0] cnt,
                                                input logic req, input logic rsp);
    if (rsp && cnt == '0)           return '0;
    if (req && rsp)                 return cnt;
    if (req && cnt != OUT_MAX)      return cnt + OUT_W'(1);
    if (rsp)                        return cnt - OUT_W'(1);
    return cnt;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    aw_hs = awvalid & awready;
    ar_hs = arvalid & arready;
    b_hs  = bvalid & bready;
    r_hs  = rvalid & rready;

    stall_d = {rvalid & ~rready, bvalid & ~bready, arvalid & ~arready,
               wvalid & ~wready, awvalid & ~awready};
    viol_new[0] = stall_q[0] & ~awvalid;
    viol_new[1] = stall_q[1] & ~wvalid;
    viol_new[2] = stall_q[2] & ~arvalid;
    viol_new[3] = stall_q[3] & ~bvalid;
    viol_new[4] = stall_q[4] & ~rvalid;
    viol_new[5] = b_hs & (wr_out_q == '0);
    viol_new[6] = r_hs & (rd_out_q == '0);
    viol_new[7] = (aw_hs & (wr_out_q == OUT_MAX)) | (ar_hs & (rd_out_q == OUT_MAX));

    wr_out_d = next_out(wr_out_q, aw_hs, b_hs);
    rd_out_d = next_out(rd_out_q, ar_hs, r_hs);

    pop  = r_hs & (fifo_cnt_q != '0);
    push = ar_hs & (rd_out_q != OUT_MAX) & ((fifo_cnt_q != OUT_MAX) | pop);
    wptr_d     = push ? next_ptr(wptr_q) : wptr_q;
    rptr_d     = pop  ? next_ptr(rptr_q) : rptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + OUT_W'(1);
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - OUT_W'(1);
    lat = ts_q - mem_q[rptr_q];

    if (clr) begin
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
      err_cnt_d = '0;
      lat_max_d = '0;
      viol_d    = '0;
    end else begin
      wr_cnt_d  = sat_add(wr_cnt_q, {1'b0, b_hs});
      rd_cnt_d  = sat_add(rd_cnt_q, {1'b0, r_hs});
      err_cnt_d = sat_add(err_cnt_q, 2'(b_hs & (bresp != 2'b00)) + 2'(r_hs & (rresp != 2'b00)));
      lat_max_d = (pop && lat > lat_max_q) ? lat : lat_max_q;
      viol_d    = viol_q | viol_new;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_q       <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      err_cnt_q  <= '0;
      lat_max_q  <= '0;
      wr_out_q   <= '0;
      rd_out_q   <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      viol_q     <= '0;
      stall_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ts_q       <= ts_q + CNT_W'(1);
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
      lat_max_q  <= lat_max_d;
      wr_out_q   <= wr_out_d;
      rd_out_q   <= rd_out_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      viol_q     <= viol_d;
      stall_q    <= stall_d;
      irq_q      <= |viol_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wptr_q] <= ts_q;
  end

  assign wr_count       = wr_cnt_q;
  assign rd_count       = rd_cnt_q;
  assign err_count      = err_cnt_q;
  assign wr_outstanding = wr_out_q;
  assign rd_outstanding = rd_out_q;
  assign rd_lat_max     = lat_max_q;
  assign viol           = viol_q;
  assign irq            = irq_q;

endmodule

// File: doc/axi_lite_pt_monitor.md
Name: axi_lite_pt_monitor

Overview:
- Passive, parametrised AXI4-Lite protocol monitor and performance counter. Taps one interface between master and slave; drives nothing onto the bus.
- Counts completed read and write transactions and error responses.
- Tracks outstanding requests per direction, measures worst-case read latency through a timestamp FIFO, and latches protocol violations into a sticky vector with an interrupt.
- Sits in the pass-through position of the simulation/example design.

Parameters:
- MAX_OUTSTANDING, 4: timestamp FIFO depth and outstanding-counter ceiling per direction; power of two, 1..16.
- CNT_W, 32: width of the transaction, error and latency counters and of the free-running timestamp.
- OUT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counts (derived, not overridable).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of counters, rd_lat_max and viol
- awvalid, awready, wvalid, wready, arvalid, arready  in  1 each  request-channel handshake taps
- bvalid, bready, rvalid, rready  in  1 each  response-channel handshake taps
- bresp, rresp  in  2 each  response codes
- wr_count, rd_count, err_count  out  CNT_W  completed writes (B handshakes), completed reads (R handshakes), non-OKAY responses
- wr_outstanding, rd_outstanding  out  OUT_W  accepted requests awaiting a response
- rd_lat_max  out  CNT_W  largest AR-to-R latency seen, in cycles
- viol  out  8  sticky violation flags
- irq  out  1  registered OR of viol

Behaviour:
- Handshake on a channel = valid & ready sampled at the aclk rising edge.
- Reset (aresetn low, asynchronous assert, synchronous release): every output, the FIFO pointers and the timestamp are 0.
- Timestamp: free-running CNT_W counter, increments every cycle and wraps. It is not affected by clr.
- Outstanding counts:
  - wr_outstanding: +1 on AW handshake, -1 on B handshake.
  - rd_outstanding: +1 on AR handshake, -1 on R handshake.
  - Both events in the same cycle with a nonzero count: count unchanged.
- Response without request:
  - A B (or R) handshake while the matching count is 0 sets viol[5] (or viol[6]).
  - The count stays at 0. A same-cycle AW/AR does not excuse it.
  - The counters still increment.
- Overflow: an AW or AR handshake while the count equals MAX_OUTSTANDING sets viol[7]. The count saturates and no timestamp is pushed.
- Timestamp FIFO:
  - Every AR handshake that is not an overflow pushes the current timestamp.
  - Every R handshake with a nonempty FIFO pops the head and computes lat = timestamp - head, modulo 2^CNT_W.
  - If lat > rd_lat_max, rd_lat_max <= lat on the next cycle.
  - Push and pop in the same cycle are both performed.
  - After an overflow, latency values are meaningless until the bus is idle.
- Valid-drop checks: for AW, W, AR, B and R, valid high with ready low in cycle n and valid low in cycle n+1 sets viol[0..4] respectively (AW, W, AR, B, R).
- Counter updates:
  - wr_count +1 per B handshake; rd_count +1 per R handshake.
  - err_count +1 per B or R handshake with resp != 2'b00. Simultaneous B and R errors add 2.
  - All CNT_W counters saturate at all-ones and never wrap.
- clr:
  - Zeroes wr_count, rd_count, err_count, rd_lat_max and viol. An event in the same cycle as clr is discarded.
  - Does not affect outstanding counts, the FIFO or the timestamp.
- Latency: irq is one cycle after viol changes. Counters and viol update one cycle after the handshake edge.
- aresetn asserted mid-transaction: all state clears immediately. Responses to requests accepted before reset are flagged as viol[5]/viol[6].

Test Plan:
- Reset release, idle bus for 20 cycles -> all outputs 0, irq 0.
- AR handshake at cycle 10, R handshake (rresp=0) at cycle 13 -> rd_count=1, rd_outstanding 1 then 0, rd_lat_max=3, err_count=0.
- Three AW handshakes, then B handshakes with bresp=0, 2, 0 -> wr_outstanding peaks at 3, wr_count=3, err_count=1, viol=0.
- MAX_OUTSTANDING=4: five AR handshakes with no R -> rd_outstanding=4, viol[7]=1, irq=1 one cycle later; clr -> viol=0 and rd_outstanding stays 4.
- awvalid=1 with awready=0 for one cycle, then awvalid=0 -> viol[0]=1. Separately, an rvalid/rready handshake at idle -> viol[6]=1 and rd_count=1.
- CNT_W=4: 17 write completions -> wr_count=15 (saturated). Reset mid-burst with 2 outstanding reads, then 2 R handshakes -> viol[6]=1, rd_outstanding=0.
